// File: rtl/nested_epc_stack.sv
// nested_epc_stack
//   LIFO stack of DEPTH exception return addresses, each stored with its
//   branch-delay flag. It replaces the single nested EPC register in CP0.
//   Hardware exception entry pushes, ERET pops, and MTC0 overwrites the
//   top entry.
//
//   Storage is a circular buffer. top_q points at the newest entry, and
//   count_q holds the number of valid entries.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   we_h       in   hardware exception entry (push adjusted pc_p)
//   r_h        in   hardware ERET (pop)
//   we_s       in   MTC0 write of write_data into the top entry
//   bd_p       in   faulting instruction sits in a branch delay slot
//   pc_p       in   PC of the faulting instruction
//   write_data in   software write value
//   clr_flags  in   clear the sticky ovf/unf flags
//   read_data  out  top-entry EPC, 0 when empty
//   bd_top     out  top-entry BD flag, 0 when empty
//   count      out  number of valid entries
//   ovf        out  sticky: push while full
//   unf        out  sticky: pop while empty
//
// Build option
//   EPC_STACK_WRAP_EN  defined  : a push on full overwrites the oldest entry
//                      undefined: a push on full is dropped
module nested_epc_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_h,
  input  logic                     r_h,
  input  logic                     we_s,
  input  logic                     bd_p,
  input  logic [WIDTH-1:0]         pc_p,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     clr_flags,
  output logic [WIDTH-1:0]         read_data,
  output logic                     bd_top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] epc_q [DEPTH];
  logic             bd_q  [DEPTH];
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Single write port into the entry array.
  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_epc;
  logic             wr_bd;
  logic             ovf_set, unf_set;

  logic             empty, full;
  logic [WIDTH-1:0] push_val;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  // A fault in a delay slot restarts at the branch. The subtraction wraps mod 2^WIDTH.
  assign push_val = bd_p ? (pc_p - WIDTH'(4)) : pc_p;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = top_q;
    wr_epc  = push_val;
    wr_bd   = bd_p;
    top_d   = top_q;
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;

    if (we_h) begin
      if (r_h && !empty) begin
        // ERET and a new exception in the same cycle: replace the top entry in place.
        wr_en = 1'b1;
      end else if (!full) begin
        top_d   = top_q + PW'(1);
        wr_idx  = top_q + PW'(1);
        wr_en   = 1'b1;
        count_d = count_q + CW'(1);
      end else begin
        ovf_set = 1'b1;
`ifdef EPC_STACK_WRAP_EN
        // Full: advancing top lands on the oldest entry, which is overwritten.
        top_d  = top_q + PW'(1);
        wr_idx = top_q + PW'(1);
        wr_en  = 1'b1;
`endif
      end
    end else if (r_h) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        top_d   = top_q - PW'(1);
        count_d = count_q - CW'(1);
      end
    end else if (we_s) begin
      wr_epc = write_data;
      wr_en  = 1'b1;
      if (empty) begin
        // An MTC0 write on an empty stack creates the first entry.
        top_d   = top_q + PW'(1);
        wr_idx  = top_q + PW'(1);
        wr_bd   = 1'b0;
        count_d = CW'(1);
      end else begin
        wr_bd = bd_q[top_q];
      end
    end

    // When a flag is set and cleared in the same cycle, the set takes effect.
    ovf_d = (ovf_q & ~clr_flags) | ovf_set;
    unf_d = (unf_q & ~clr_flags) | unf_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        epc_q[i] <= '0;
        bd_q[i]  <= 1'b0;
      end
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_en) begin
        epc_q[wr_idx] <= wr_epc;
        bd_q[wr_idx]  <= wr_bd;
      end
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign read_data = empty ? '0 : epc_q[top_q];
  assign bd_top    = empty ? 1'b0 : bd_q[top_q];
  assign count     = count_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_nested_epc_stack.sv
module tb_nested_epc_stack;

  localparam int W = 32;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          we_h, r_h, we_s, bd_p, clr_flags;
  logic [W-1:0]  pc_p, write_data;
  logic [W-1:0]  read_data;
  logic          bd_top, ovf, unf;
  logic [2:0]    count;

  nested_epc_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .we_h(we_h), .r_h(r_h), .we_s(we_s),
    .bd_p(bd_p), .pc_p(pc_p), .write_data(write_data), .clr_flags(clr_flags),
    .read_data(read_data), .bd_top(bd_top), .count(count), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of {bd, epc} entries, with the newest entry at the back.
  logic [W:0] q[$];
  bit         m_ovf, m_unf;
  int         n_vec, n_err;
  bit         chk_en;

  task automatic cmp(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // Compare process: outputs depend only on registered state, so they are sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_read_data", read_data, (q.size() != 0) ? q[$][W-1:0] : '0);
      cmp("model_bd_top", {31'b0, bd_top}, {31'b0, (q.size() != 0) ? q[$][W] : 1'b0});
      cmp("model_count", {29'b0, count}, q.size());
      cmp("model_ovf", {31'b0, ovf}, {31'b0, m_ovf});
      cmp("model_unf", {31'b0, unf}, {31'b0, m_unf});
    end
  end

  task automatic model_update();
    logic [W-1:0] pv;
    bit so, su;
    so = 0; su = 0;
    pv = bd_p ? pc_p - 32'd4 : pc_p;
    if (we_h && r_h) begin
      if (q.size() == 0) q.push_back({bd_p, pv});
      else q[$] = {bd_p, pv};
    end else if (we_h) begin
      if (q.size() < D) q.push_back({bd_p, pv});
      else begin
        so = 1;
`ifdef EPC_STACK_WRAP_EN
        void'(q.pop_front());
        q.push_back({bd_p, pv});
`endif
      end
    end else if (r_h) begin
      if (q.size() == 0) su = 1;
      else void'(q.pop_back());
    end else if (we_s) begin
      if (q.size() == 0) q.push_back({1'b0, write_data});
      else q[$] = {q[$][W], write_data};
    end
    m_ovf = (m_ovf && !clr_flags) || so;
    m_unf = (m_unf && !clr_flags) || su;
  endtask

  task automatic step(input bit wh, input bit rh, input bit ws, input bit bd,
                      input logic [W-1:0] pc, input logic [W-1:0] wd, input bit clr);
    we_h = wh; r_h = rh; we_s = ws; bd_p = bd; pc_p = pc; write_data = wd; clr_flags = clr;
    @(posedge clk);
    model_update();
    @(negedge clk);
    we_h = 0; r_h = 0; we_s = 0; bd_p = 0; pc_p = '0; write_data = '0; clr_flags = 0;
  endtask

  task automatic push(input logic [W-1:0] pc, input bit bd);
    step(1, 0, 0, bd, pc, '0, 0);
  endtask
  task automatic pop();
    step(0, 1, 0, 0, '0, '0, 0);
  endtask
  task automatic wr(input logic [W-1:0] wd);
    step(0, 0, 1, 0, '0, wd, 0);
  endtask
  task automatic clr();
    step(0, 0, 0, 0, '0, '0, 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; chk_en = 0;
    m_ovf = 0; m_unf = 0;
    we_h = 0; r_h = 0; we_s = 0; bd_p = 0; pc_p = '0; write_data = '0; clr_flags = 0;
    rst = 1'b0;
    #1;
    chk_en = 1;
    @(negedge clk);
    cmp("reset_read_data", read_data, 32'h0);
    cmp("reset_count", {29'b0, count}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Basic push and pop
    push(32'h8000_1000, 0);
    cmp("push_read_data", read_data, 32'h8000_1000);
    cmp("push_count", {29'b0, count}, 32'd1);
    pop();
    cmp("pop_read_data", read_data, 32'h0);
    cmp("pop_unf", {31'b0, unf}, 32'd0);

    // BD adjust and modular wrap
    push(32'h0040_0010, 1);
    cmp("bd_adjust", read_data, 32'h0040_000C);
    cmp("bd_top_set", {31'b0, bd_top}, 32'd1);
    push(32'h0000_0000, 1);
    cmp("bd_wrap", read_data, 32'hFFFF_FFFC);
    pop(); pop();

    // Nesting order
    push(32'h100, 0); push(32'h200, 0); push(32'h300, 0);
    pop(); cmp("nest_pop1", read_data, 32'h200);
    pop(); cmp("nest_pop2", read_data, 32'h100);
    pop(); cmp("nest_pop3", read_data, 32'h0);
    cmp("nest_count", {29'b0, count}, 32'd0);

    // Overflow
    push(32'h10, 0); push(32'h20, 0); push(32'h30, 0); push(32'h40, 0); push(32'h50, 0);
    cmp("ovf_set", {31'b0, ovf}, 32'd1);
    cmp("ovf_count", {29'b0, count}, 32'd4);
`ifdef EPC_STACK_WRAP_EN
    pop(); cmp("ovf_pop1", read_data, 32'h40);
    pop(); cmp("ovf_pop2", read_data, 32'h30);
    pop(); cmp("ovf_pop3", read_data, 32'h20);
`else
    pop(); cmp("ovf_pop1", read_data, 32'h30);
    pop(); cmp("ovf_pop2", read_data, 32'h20);
    pop(); cmp("ovf_pop3", read_data, 32'h10);
`endif
    pop(); cmp("ovf_pop4", read_data, 32'h0);
    clr();
    cmp("ovf_clr", {31'b0, ovf}, 32'd0);

    // Underflow and flags
    pop();
    cmp("unf_set", {31'b0, unf}, 32'd1);
    clr();
    cmp("unf_clr", {31'b0, unf}, 32'd0);
    step(0, 1, 0, 0, '0, '0, 1);
    cmp("unf_set_wins", {31'b0, unf}, 32'd1);
    clr();

    // Simultaneous events
    push(32'h100, 0);
    step(1, 1, 0, 0, 32'h500, '0, 0);
    cmp("replace_top", read_data, 32'h500);
    cmp("replace_count", {29'b0, count}, 32'd1);
    step(1, 0, 1, 0, 32'h600, 32'hDEAD, 0);
    cmp("weh_over_wes", read_data, 32'h600);
    cmp("weh_over_wes_count", {29'b0, count}, 32'd2);
    pop(); pop();
    wr(32'h700);
    cmp("wes_empty_count", {29'b0, count}, 32'd1);
    cmp("wes_empty_data", read_data, 32'h700);
    cmp("wes_empty_bd", {31'b0, bd_top}, 32'd0);

    // MTC0 on a nonempty stack keeps the BD flag
    push(32'h1004, 1);
    wr(32'h2222);
    cmp("wes_keeps_bd_data", read_data, 32'h2222);
    cmp("wes_keeps_bd", {31'b0, bd_top}, 32'd1);
    step(0, 1, 1, 0, '0, 32'h9999, 0);
    cmp("pop_over_wes", read_data, 32'h700);

    // ERET and exception entry on an empty stack is a plain push with no underflow
    pop();
    step(1, 1, 0, 0, 32'h4440, '0, 0);
    cmp("replace_empty", read_data, 32'h4440);
    cmp("replace_empty_unf", {31'b0, unf}, 32'd0);

    // Replace when full; a push together with clr still sets ovf
    push(32'hA1, 0); push(32'hA2, 0); push(32'hA3, 0);
    step(1, 1, 0, 0, 32'hB0, '0, 0);
    cmp("replace_full", read_data, 32'hB0);
    cmp("replace_full_ovf", {31'b0, ovf}, 32'd0);
    step(1, 0, 0, 0, 32'hC0, '0, 1);
    cmp("ovf_set_wins", {31'b0, ovf}, 32'd1);

    // An asynchronous reset mid-sequence discards all entries
    #2;
    rst = 1'b0;
    q.delete(); m_ovf = 0; m_unf = 0;
    #1;
    cmp("async_rst_count", {29'b0, count}, 32'd0);
    cmp("async_rst_data", read_data, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    push(32'h1234, 0);
    cmp("post_rst_push", read_data, 32'h1234);
    @(negedge clk);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
